source_loader: RTL and testbench
================================

SOURCE_LOADER -- requirements
Module: source_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning words per frame; legal range 2..256.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning sample width, signed two's complement.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, DATA_W bits, signed: incoming sample.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port M10K_write_data_source, output, DATA_W bits, signed: source-memory write data.
REQ-009 The block SHALL have port M10K_write_address_source, output, 8 bits: source-memory write address.
REQ-010 The block SHALL have port M10K_write_source, output, 1 bit: source-memory write enable.
REQ-011 The block SHALL have port START, output, 1 bit: frame loaded, compute may run; level signal.
REQ-012 The block SHALL have port compute_done, input, 1 bit: downstream compute finished the current frame.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except LOAD with zero words accepted.
REQ-014 The block SHALL have port frame_count, output, 16 bits: frames completed since reset.

Function
REQ-015 The FSM SHALL have states LOAD, COMMIT, RUN; the reset state SHALL be LOAD with word counter 0.
REQ-016 in_ready SHALL be 1 only in LOAD and be registered-free (combinational from state).
REQ-017 A word SHALL be accepted on a cycle with in_valid=1 and in_ready=1; in_valid without in_ready SHALL have no effect, and in_data SHALL be ignored.
REQ-018 Each accepted word SHALL produce M10K_write_source=1 for exactly one cycle on the next cycle, with address equal to the word counter value at acceptance and the data unchanged; write latency SHALL be 1 cycle.
REQ-019 The write enable SHALL be 0 on any cycle following a non-accepting cycle; address/data MAY hold their last values.
REQ-020 The word counter SHALL increment per accepted word; accepting word DEPTH-1 SHALL move LOAD->COMMIT and clear the counter (wrap to 0; no 9-bit carry).
REQ-021 COMMIT SHALL last exactly one cycle (the last write is issued) and then move to RUN.
REQ-022 START SHALL be 1 in RUN and 0 in all other states; it SHALL rise only after the last write has been issued.
REQ-023 In RUN, compute_done=1 SHALL move RUN->LOAD on the next edge, deassert START, and increment frame_count by 1 (wraps 65535->0).
REQ-024 compute_done SHALL be ignored in LOAD and COMMIT; if held high continuously, each RUN entry SHALL still last at least one cycle.
REQ-025 Gaps in in_valid SHALL only stall loading; there is no timeout.

Reset
REQ-026 On a reset edge, the outputs SHALL be: in_ready=1 (LOAD), M10K_write_source=0, M10K_write_address_source=0, M10K_write_data_source=0, START=0, busy=0, frame_count=0, with the counter at 0.
REQ-027 A reset mid-LOAD, COMMIT or RUN SHALL abort the frame: the partial frame is discarded, no write occurs on the cycle after reset, and no done credit is retained.

Structure
REQ-028 The shared package SHALL hold the state enum (LOAD, COMMIT, RUN), DATA_W, DEPTH and the memory address width of 8.
REQ-029 The block SHALL be a single module with no sub-modules; the M10K itself is external.

Verification
REQ-030 Reset then stream 256 words 0,1,...,255 (as signed, -1 = 8'hFF) back to back -> 256 single-cycle writes at address n, data n, each 1 cycle after acceptance; COMMIT 1 cycle; START rises 2 cycles after the last accept.
REQ-031 Toggle in_valid 1/0 every cycle over a frame -> exactly 256 writes, no address skipped or repeated, in_ready stays 1 throughout LOAD.
REQ-032 In RUN, drive in_valid=1 with data 8'h7F for 10 cycles, then pulse compute_done -> no writes in RUN, START falls next edge, frame_count=1, and the next accepted word is written to address 0.
REQ-033 Pulse compute_done during LOAD at word 100 -> no state change; frame completes normally, frame_count stays 0 until a done in RUN.
REQ-034 Assert reset at word 37 and at a RUN cycle -> next cycle: write enable 0, START 0, counter 0; a new full frame is written from address 0.
REQ-035 With DEPTH=4, run 3 frames holding compute_done high -> START high exactly 1 cycle per frame, frame_count=3, addresses wrap 0..3.

Source files
------------

// File: rtl/source_loader_pkg.sv
// source_loader_pkg: shared state encoding and sizing for the source-memory loader.
package source_loader_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  typedef enum logic [1:0] {LOAD, COMMIT, RUN} state_e;
endpackage

// File: rtl/source_loader.sv
// source_loader: streams one frame of samples into the external source M10K, then holds START until compute_done.
module source_loader #(
  parameter int DEPTH  = source_loader_pkg::DEPTH,
  parameter int DATA_W = source_loader_pkg::DATA_W
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic signed [DATA_W-1:0]              in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic signed [DATA_W-1:0]              M10K_write_data_source,
  output logic [source_loader_pkg::ADDR_W-1:0]  M10K_write_address_source,
  output logic                                  M10K_write_source,
  output logic                                  START,
  input  logic                                  compute_done,
  output logic                                  busy,
  output logic [15:0]                           frame_count
);
  import source_loader_pkg::*;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d, addr_q, addr_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     wr_q, wr_d;
  logic [15:0]              frames_q, frames_d;
  logic                     accept, last, done;
  assign in_ready                  = state_q == LOAD;
  assign START                     = state_q == RUN;
  assign busy                      = state_q != LOAD || cnt_q != '0;
  assign M10K_write_source         = wr_q;
  assign M10K_write_address_source = addr_q;
  assign M10K_write_data_source    = data_q;
  assign frame_count               = frames_q;
  always_comb begin
    accept   = in_valid && in_ready;
    last     = accept && cnt_q == LAST;
    done     = state_q == RUN && compute_done;
    wr_d     = accept;
    addr_d   = accept ? cnt_q : addr_q;
    data_d   = accept ? in_data : data_q;
    cnt_d    = last ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
    frames_d = frames_q + 16'(done);
    state_d  = state_q == COMMIT ? RUN : done ? LOAD : last ? COMMIT : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      frames_q <= frames_d;
    end
  end
endmodule

// File: tb/tb_source_loader.sv
// tb_source_loader: scoreboard bench for a 256-deep loader plus a 4-deep instance for wrap/held-done behaviour.
module tb_source_loader;
  logic clk = 0;
  always #5 clk = ~clk;
  logic       rst, in_valid, compute_done, in_ready, wr, start, busy;
  logic [7:0] in_data, wdata, waddr;
  logic [15:0] fcount;
  logic       s_rst, s_valid, s_done, s_ready, s_wr, s_start, s_busy;
  logic [7:0] s_data, s_wdata, s_waddr;
  logic [15:0] s_fcount;
  source_loader dut (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .M10K_write_data_source(wdata), .M10K_write_address_source(waddr), .M10K_write_source(wr),
    .START(start), .compute_done(compute_done), .busy(busy), .frame_count(fcount)
  );
  source_loader #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(s_rst), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
    .M10K_write_data_source(s_wdata), .M10K_write_address_source(s_waddr), .M10K_write_source(s_wr),
    .START(s_start), .compute_done(s_done), .busy(s_busy), .frame_count(s_fcount)
  );
  typedef struct packed {logic [7:0] a; logic [7:0] d; logic [31:0] c;} wr_t;
  wr_t        sb[$];
  wr_t        it;
  int         n_chk = 0, n_fail = 0, cyc = 0, wr_n = 0, s_wr_n = 0, s_start_n = 0, s_exp = 0;
  logic [7:0] exp_addr = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic done, input logic r);
    in_valid = v; in_data = d; compute_done = done; rst = r;
    if (r) exp_addr = 0;
    else if (v && in_ready) begin
      sb.push_back('{a: exp_addr, d: d, c: cyc + 1});
      exp_addr++;
    end
    @(posedge clk); #1;
  endtask
  task automatic s_step(input logic v, input logic r);
    s_valid = v; s_data = 8'($urandom); s_done = 1'b1; s_rst = r;
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (wr) begin
      if (sb.size() == 0) check("wr_unexpected", sb.size(), 1);
      else begin
        it = sb.pop_front();
        check("wr_addr", waddr, it.a);
        check("wr_data", wdata, it.d);
        check("wr_latency", cyc, it.c);
      end
      wr_n++;
    end
    if (s_wr) begin
      check("d4_addr", s_waddr, s_exp);
      s_exp = (s_exp + 1) % 4;
      s_wr_n++;
    end
    if (s_start) s_start_n++;
  end
  task automatic finish_frame(input int exp_writes);
    check("commit_start", start, 0);
    check("commit_ready", in_ready, 0);
    check("commit_busy", busy, 1);
    step(0, 0, 0, 0);
    check("run_start", start, 1);
    check("frame_writes", wr_n, exp_writes);
  endtask
  initial begin
    s_rst = 1; s_valid = 0; s_done = 0; s_data = 0;
    repeat (2) step(0, 0, 0, 1);
    check("rst_ready", in_ready, 1);
    check("rst_wr", wr, 0);
    check("rst_addr", waddr, 0);
    check("rst_data", wdata, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_fcount", fcount, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 256; i++) step(1, 8'(i), 0, 0);
    finish_frame(256);
    repeat (10) step(1, 8'h7F, 0, 0);
    check("run_hold_start", start, 1);
    check("run_no_writes", wr_n, 256);
    step(0, 0, 1, 0);
    check("done_start", start, 0);
    check("done_fcount", fcount, 1);
    check("done_ready", in_ready, 1);
    check("done_busy", busy, 0);
    begin
      int w = 0, drops = 0;
      logic v = 0;
      while (w < 256) begin
        v = !v;
        if (!in_ready) drops++;
        step(v, 8'($urandom), v && w == 100, 0);
        if (v) w++;
      end
      check("toggle_ready_drops", drops, 0);
      check("load_done_fcount", fcount, 1);
    end
    finish_frame(512);
    step(0, 0, 1, 0);
    check("f2_fcount", fcount, 2);
    for (int i = 0; i < 37; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'h55, 0, 1);
    check("rstload_wr", wr, 0);
    check("rstload_start", start, 0);
    check("rstload_busy", busy, 0);
    check("rstload_fcount", fcount, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 256; i++) step(1, 8'(255 - i), 0, 0);
    finish_frame(512 + 37 + 256);
    step(0, 0, 0, 1);
    check("rstrun_start", start, 0);
    check("rstrun_wr", wr, 0);
    check("rstrun_ready", in_ready, 1);
    check("rstrun_busy", busy, 0);
    step(0, 0, 0, 0);
    check("sb_empty", sb.size(), 0);
    s_step(0, 1);
    s_step(0, 0);
    for (int f = 0; f < 3; f++) begin
      repeat (4) s_step(1, 0);
      check("d4_commit_start", s_start, 0);
      s_step(0, 0);
      check("d4_run_start", s_start, 1);
      s_step(0, 0);
      check("d4_start_cycles", s_start_n, f + 1);
      check("d4_back_to_load", s_ready, 1);
    end
    check("d4_fcount", s_fcount, 3);
    check("d4_writes", s_wr_n, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
